// File: rtl/color_bounce_renderer.sv
// color_bounce_renderer
//
// Takes one game-state snapshot on a frame tick and turns it into a pixel stream
// for a 160x120, 3-bit-colour VGA adapter. The drawing order is fixed: erase the
// previous ball, draw the four platforms, then draw the current ball. Exactly one
// pixel is produced per cycle. Pixels that fall off screen still use their cycle,
// but they are not plotted.
//
// Optional feature: define COLOR_BOUNCE_SKIP_UNCHANGED_EN to skip the erase pass
// when the previous and current ball rows are equal.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-low reset
//   start          frame tick, sampled only while idle
//   prev_ball      previous ball top row (bit 7 ignored)
//   curr_ball      current ball top row (bit 7 ignored)
//   color_ball     ball colour
//   color_plats    platform i colour = [3i+2:3i]
//   position_plats platform i left x = [7i+6:7i]
//   x, y, colour   registered pixel coordinate and colour
//   plot           write strobe to the VGA adapter
//   busy           high while a frame is in progress
//   done           one-cycle pulse when a frame completes
module color_bounce_renderer #(
    parameter int unsigned BALL_X    = 76,
    parameter int unsigned BALL_SIZE = 4,
    parameter int unsigned PLAT_Y    = 100,
    parameter int unsigned PLAT_W    = 10,
    parameter int unsigned PLAT_H    = 2,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  prev_ball,
    input  logic [7:0]  curr_ball,
    input  logic [2:0]  color_ball,
    input  logic [11:0] color_plats,
    input  logic [27:0] position_plats,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam int unsigned NumPlats = 4;
    localparam int unsigned ScreenW  = 160;
    localparam int unsigned ScreenH  = 120;
    localparam int unsigned MaxW     = (PLAT_W > BALL_SIZE) ? PLAT_W : BALL_SIZE;
    localparam int unsigned MaxH     = (PLAT_H > BALL_SIZE) ? PLAT_H : BALL_SIZE;
    localparam int unsigned ColW     = (MaxW > 1) ? $clog2(MaxW) : 1;
    localparam int unsigned RowW     = (MaxH > 1) ? $clog2(MaxH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StErase,
        StPlat,
        StBall,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [1:0]        plat_q, plat_d;

    // Snapshot registers; ball rows are stored with bit 7 already cleared.
    logic [7:0]        prev_q, curr_q;
    logic [2:0]        cball_q;
    logic [11:0]       cplats_q;
    logic [27:0]       pos_q;

    logic [7:0]        x_q;
    logic [6:0]        y_q;
    logic [2:0]        colour_q;
    logic              plot_q, busy_q, done_q;

    logic [7:0]        pix_x, pix_y;
    logic [2:0]        pix_c;
    logic              pix_on;
    logic              pix_vis;
    logic [7:0]        ball_row;

    logic [6:0]        plat_pos [NumPlats];
    logic [2:0]        plat_col [NumPlats];

    always_comb begin
        for (int i = 0; i < NumPlats; i++) begin
            plat_pos[i] = pos_q[7*i +: 7];
            plat_col[i] = cplats_q[3*i +: 3];
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        plat_d   = plat_q;
        pix_x    = '0;
        pix_y    = '0;
        pix_c    = '0;
        pix_on   = 1'b0;
        ball_row = (state_q == StErase) ? prev_q : curr_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                end
            end

            StLoad: begin
                col_d   = '0;
                row_d   = '0;
                plat_d  = '0;
                state_d = StErase;
`ifdef COLOR_BOUNCE_SKIP_UNCHANGED_EN
                // Compare the values being latched this cycle.
                if ((prev_ball & 8'h7F) == (curr_ball & 8'h7F)) begin
                    state_d = StPlat;
                end
`endif
            end

            StErase, StBall: begin
                pix_x  = 8'(BALL_X) + 8'(col_q);
                pix_y  = ball_row + 8'(row_q);
                pix_c  = (state_q == StErase) ? BG_COLOUR : cball_q;
                pix_on = 1'b1;
                if (col_q == ColW'(BALL_SIZE - 1)) begin
                    col_d = '0;
                    if (row_q == RowW'(BALL_SIZE - 1)) begin
                        row_d   = '0;
                        state_d = (state_q == StErase) ? StPlat : StDone;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end

            StPlat: begin
                pix_x  = {1'b0, plat_pos[plat_q]} + 8'(col_q);
                pix_y  = 8'(PLAT_Y) + 8'(row_q);
                pix_c  = plat_col[plat_q];
                pix_on = 1'b1;
                if (col_q == ColW'(PLAT_W - 1)) begin
                    col_d = '0;
                    if (row_q == RowW'(PLAT_H - 1)) begin
                        row_d = '0;
                        if (plat_q == 2'(NumPlats - 1)) begin
                            plat_d  = '0;
                            state_d = StBall;
                        end else begin
                            plat_d = plat_q + 1'b1;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Off-screen pixels still take their cycle but are not strobed.
    assign pix_vis = pix_on && (pix_x < 8'(ScreenW)) && (pix_y < 8'(ScreenH));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            col_q    <= '0;
            row_q    <= '0;
            plat_q   <= '0;
            prev_q   <= '0;
            curr_q   <= '0;
            cball_q  <= '0;
            cplats_q <= '0;
            pos_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            plat_q  <= plat_d;
            if (state_q == StLoad) begin
                prev_q   <= prev_ball & 8'h7F;
                curr_q   <= curr_ball & 8'h7F;
                cball_q  <= color_ball;
                cplats_q <= color_plats;
                pos_q    <= position_plats;
            end
            x_q      <= pix_x;
            y_q      <= pix_y[6:0];
            colour_q <= pix_c;
            plot_q   <= pix_vis;
            busy_q   <= (state_q != StIdle);
            done_q   <= (state_q == StDone);
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
